queue_ctrl: RTL and testbench

Sequencing controller for the bank-queue wait-time ROM. It counts customers from entry and exit photo-sensors and latches the active teller count. It drives the ROM address (pcount, tcount) and registers the ROM's wait-time answer for the display. It also reports queue status and flags illegal events.

---
 rtl/queue_ctrl_if.sv | 34 +++
 rtl/queue_ctrl.sv | 137 +++++++++++++
 tb/tb_queue_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/queue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : queue_ctrl_if
// Purpose : Sensor, teller-select, ROM and status bundle for queue_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface queue_ctrl_if #(
    parameter int CNT_W = 4,
    parameter int WT_W  = 5
);
    logic             entry_sensor;
    logic             exit_sensor;
    logic [1:0]       teller_sel;
    logic [WT_W-1:0]  wtime_in;
    logic [CNT_W-1:0] pcount;
    logic [1:0]       tcount;
    logic [WT_W-1:0]  wtime;
    logic             full;
    logic             empty;
    logic             open;
    logic             ovf;
    logic             unf;

    modport master (
        output entry_sensor, exit_sensor, teller_sel, wtime_in,
        input  pcount, tcount, wtime, full, empty, open, ovf, unf
    );

    modport slave (
        input  entry_sensor, exit_sensor, teller_sel, wtime_in,
        output pcount, tcount, wtime, full, empty, open, ovf, unf
    );
endinterface
`default_nettype wire

// File: rtl/queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : queue_ctrl
// Purpose : Counts queue occupancy from photo-sensors, addresses the wait-time
//           ROM and registers its answer, status and sticky error flags.
// Revision: 1.0 - initial release
// ============================================================================
module queue_ctrl #(
    parameter int MAX_COUNT = 7,
    parameter int CNT_W     = 4,
    parameter int WT_W      = 5
) (
    input  logic         clk,
    input  logic         rst,
    queue_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);

    typedef enum logic [0:0] {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             ent_s1_q, ent_s2_q, ent_s2d_q;
    logic             ent_s1_d, ent_s2_d, ent_s2d_d;
    logic             ext_s1_q, ext_s2_q, ext_s2d_q;
    logic             ext_s1_d, ext_s2_d, ext_s2d_d;
    logic [CNT_W-1:0] pcount_q, pcount_d;
    logic [1:0]       tcount_q, tcount_d;
    logic [WT_W-1:0]  wtime_q, wtime_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ent_evt, ext_evt;

    always_comb begin
        ent_s1_d  = bus.entry_sensor;
        ent_s2_d  = ent_s1_q;
        ent_s2d_d = ent_s2_q;
        ext_s1_d  = bus.exit_sensor;
        ext_s2_d  = ext_s1_q;
        ext_s2d_d = ext_s2_q;

        // Entries are meaningless while closed; exits still drain the queue.
        ent_evt = ent_s2_q & ~ent_s2d_q & (state_q == ST_OPEN);
        ext_evt = ext_s2_q & ~ext_s2d_q;

        state_d  = state_q;
        tcount_d = tcount_q;
        pcount_d = pcount_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            ST_CLOSED: begin
                tcount_d = 2'd0;
                if (bus.teller_sel != 2'd0) begin
                    state_d  = ST_OPEN;
                    tcount_d = bus.teller_sel;
                end
            end
            default: begin
                tcount_d = bus.teller_sel;
                if (bus.teller_sel == 2'd0) begin
                    state_d = ST_CLOSED;
                end
            end
        endcase

        // Simultaneous entry and exit is a net-zero move and never flags.
        if (ent_evt && !ext_evt) begin
            if (pcount_q < MAX_CNT) begin
                pcount_d = pcount_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ext_evt && !ent_evt) begin
            if (pcount_q != '0) begin
                pcount_d = pcount_q - 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end

        full_d  = (pcount_d == MAX_CNT);
        empty_d = (pcount_d == '0);

        // The ROM has no defined answer for zero tellers.
        wtime_d = (tcount_q != 2'd0) ? bus.wtime_in : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLOSED;
            ent_s1_q  <= 1'b0;
            ent_s2_q  <= 1'b0;
            ent_s2d_q <= 1'b0;
            ext_s1_q  <= 1'b0;
            ext_s2_q  <= 1'b0;
            ext_s2d_q <= 1'b0;
            pcount_q  <= '0;
            tcount_q  <= 2'd0;
            wtime_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ent_s1_q  <= ent_s1_d;
            ent_s2_q  <= ent_s2_d;
            ent_s2d_q <= ent_s2d_d;
            ext_s1_q  <= ext_s1_d;
            ext_s2_q  <= ext_s2_d;
            ext_s2d_q <= ext_s2d_d;
            pcount_q  <= pcount_d;
            tcount_q  <= tcount_d;
            wtime_q   <= wtime_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign bus.pcount = pcount_q;
    assign bus.tcount = tcount_q;
    assign bus.wtime  = wtime_q;
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.open   = (state_q == ST_OPEN);
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_queue_ctrl
// Purpose : Scoreboard bench for queue_ctrl with a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_queue_ctrl;
    localparam int MAX = 7;

    logic clk;
    logic rst;

    queue_ctrl_if #(.CNT_W(4), .WT_W(5)) bus ();

    queue_ctrl #(.MAX_COUNT(MAX), .CNT_W(4), .WT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait-time ROM stand-in; a few entries pinned to known answers.
    function automatic logic [4:0] rom(input int p, input int t);
        if (t == 1 && p == 3) return 5'd9;
        if (t == 3 && p == 3) return 5'd5;
        if (t == 2 && p == 7) return 5'd12;
        return 5'((p * 7 + t * 11 + 3) % 32);
    endfunction

    assign bus.wtime_in = rom(int'(bus.pcount), int'(bus.tcount));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int p; int t; int w;
        int full; int empty; int open; int ovf; int unf;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: sensor sample history, occupancy arithmetic, teller follows select.
    int   m_p = 0, m_t = 0, m_w = 0, m_ovf = 0, m_unf = 0;
    logic [2:0] eh = '0, xh = '0;

    always @(posedge clk) begin
        exp_t e;
        bit ev_ent, ev_ext;
        if (rst) begin
            m_p = 0; m_t = 0; m_w = 0; m_ovf = 0; m_unf = 0;
            eh = '0; xh = '0;
        end else begin
            // A rise sampled two edges ago becomes an event now.
            ev_ent = eh[1] && !eh[2] && (m_t != 0);
            ev_ext = xh[1] && !xh[2];
            m_w = (m_t != 0) ? int'(rom(m_p, m_t)) : 0;
            m_t = int'(bus.teller_sel);
            if (ev_ent && !ev_ext) begin
                if (m_p == MAX) m_ovf = 1; else m_p = m_p + 1;
            end else if (ev_ext && !ev_ent) begin
                if (m_p == 0) m_unf = 1; else m_p = m_p - 1;
            end
            eh = {eh[1:0], bus.entry_sensor};
            xh = {xh[1:0], bus.exit_sensor};
        end
        e.p = m_p; e.t = m_t; e.w = m_w;
        e.full = (m_p == MAX) ? 1 : 0;
        e.empty = (m_p == 0) ? 1 : 0;
        e.open = (m_t != 0) ? 1 : 0;
        e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pcount", int'(bus.pcount), e.p);
            chk("sb_tcount", int'(bus.tcount), e.t);
            chk("sb_wtime",  int'(bus.wtime),  e.w);
            chk("sb_full",   int'(bus.full),   e.full);
            chk("sb_empty",  int'(bus.empty),  e.empty);
            chk("sb_open",   int'(bus.open),   e.open);
            chk("sb_ovf",    int'(bus.ovf),    e.ovf);
            chk("sb_unf",    int'(bus.unf),    e.unf);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit en, input bit ex, input int hi);
        @(negedge clk);
        bus.entry_sensor = en;
        bus.exit_sensor  = ex;
        cycles(hi);
        bus.entry_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        cycles(4);
    endtask

    task automatic pulses(input bit en, input bit ex, input int n);
        for (int i = 0; i < n; i++) pulse(en, ex, 4);
    endtask

    initial begin
        rst = 1'b1;
        bus.entry_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        bus.teller_sel   = 2'd0;
        cycles(3);
        chk("rst_pcount", int'(bus.pcount), 0);
        chk("rst_empty",  int'(bus.empty),  1);
        chk("rst_open",   int'(bus.open),   0);
        rst = 1'b0;

        bus.teller_sel = 2'd1;
        cycles(2);
        pulses(1, 0, 3);
        chk("fill3_pcount", int'(bus.pcount), 3);
        chk("fill3_tcount", int'(bus.tcount), 1);
        chk("fill3_wtime",  int'(bus.wtime),  9);
        chk("fill3_empty",  int'(bus.empty),  0);

        bus.teller_sel = 2'd3;
        cycles(3);
        chk("t3_tcount", int'(bus.tcount), 3);
        chk("t3_wtime",  int'(bus.wtime),  5);

        bus.teller_sel = 2'd2;
        pulses(1, 0, 8);
        chk("sat_pcount", int'(bus.pcount), 7);
        chk("sat_full",   int'(bus.full),   1);
        chk("sat_ovf",    int'(bus.ovf),    1);
        chk("sat_wtime",  int'(bus.wtime),  12);
        pulses(0, 1, 1);
        chk("dec6_pcount", int'(bus.pcount), 6);
        chk("dec6_full",   int'(bus.full),   0);
        chk("dec6_ovf",    int'(bus.ovf),    1);

        pulses(1, 0, 1);
        pulses(1, 1, 1);
        chk("both_full_pcount", int'(bus.pcount), 7);
        chk("both_full_unf",    int'(bus.unf),    0);
        pulses(0, 1, 7);
        pulses(1, 1, 1);
        chk("both_empty_pcount", int'(bus.pcount), 0);
        chk("both_empty_unf",    int'(bus.unf),    0);
        pulses(0, 1, 1);
        chk("unf_pcount", int'(bus.pcount), 0);
        chk("unf_flag",   int'(bus.unf),    1);

        pulses(1, 0, 4);
        bus.teller_sel = 2'd0;
        cycles(3);
        chk("close_open",   int'(bus.open),   0);
        chk("close_tcount", int'(bus.tcount), 0);
        chk("close_wtime",  int'(bus.wtime),  0);
        pulses(1, 0, 1);
        chk("closed_ent_pcount", int'(bus.pcount), 4);
        pulses(0, 1, 2);
        chk("drain_pcount", int'(bus.pcount), 2);

        bus.teller_sel = 2'd2;
        cycles(2);
        pulse(1, 0, 20);
        chk("hold_pcount", int'(bus.pcount), 3);

        // Edge captured by the synchronizer, then reset lands on it.
        @(negedge clk);
        bus.entry_sensor = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        bus.entry_sensor = 1'b0;
        @(negedge clk);
        chk("midrst_pcount", int'(bus.pcount), 0);
        chk("midrst_tcount", int'(bus.tcount), 0);
        chk("midrst_wtime",  int'(bus.wtime),  0);
        chk("midrst_ovf",    int'(bus.ovf),    0);
        chk("midrst_unf",    int'(bus.unf),    0);
        rst = 1'b0;
        cycles(6);
        chk("post_rst_pcount", int'(bus.pcount), 0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.teller_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) bus.entry_sensor = ~bus.entry_sensor;
            if ($urandom_range(0, 2) == 0) bus.exit_sensor  = ~bus.exit_sensor;
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        cycles(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
